// File: rtl/writeback_packer_if.sv
// Bus between the PE groups and the writeback packer, and from the packer to the feature-map BRAMs.
// The master side drives samples and control; the slave side is the packer itself.
interface writeback_packer_if #(
    parameter int NUM_CH    = 2,
    parameter int NUM_TERMS = 5,
    parameter int DW        = 8,
    parameter int LANES     = 8,
    parameter int AW        = 12
) ();
    localparam int WW = 8 * LANES;

    logic                            start;
    logic [AW-1:0]                   base_addr;
    logic                            relu_en;
    logic                            sat_en;
    logic                            sum_valid;
    logic [NUM_CH*NUM_TERMS*DW-1:0]  sum_in;
    logic                            flush;
    logic                            we;
    logic [AW-1:0]                   addr;
    logic [NUM_CH*WW-1:0]            din;
    logic                            busy;
    logic                            done;
    logic [AW:0]                     word_count;

    modport master (
        output start, base_addr, relu_en, sat_en, sum_valid, sum_in, flush,
        input  we, addr, din, busy, done, word_count
    );

    modport slave (
        input  start, base_addr, relu_en, sat_en, sum_valid, sum_in, flush,
        output we, addr, din, busy, done, word_count
    );
endinterface

// File: rtl/writeback_packer.sv
// Reduces partial sums per channel, post-processes to 8-bit activations and packs LANES
// activations per channel into one BRAM word, written to all channels in parallel.
module writeback_packer #(
    parameter int NUM_CH    = 2,
    parameter int NUM_TERMS = 5,
    parameter int DW        = 8,
    parameter int LANES     = 8,
    parameter int AW        = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_packer_if.slave    bus
);
    localparam int WW = 8 * LANES;
    localparam int SW = DW + $clog2(NUM_TERMS);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic signed [SW-1:0] SAT_MAX = 127;
    localparam logic signed [SW-1:0] SAT_MIN = -128;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t                 r_state, w_state_next;
    logic                   r_drain_cnt;
    logic                   r_s1_valid, r_s1_relu, r_s1_sat;
    logic signed [SW-1:0]   r_s1_sum [NUM_CH];
    logic                   r_s2_valid;
    logic [7:0]             r_s2_byte [NUM_CH];
    logic [LW-1:0]          r_lane;
    logic [WW-1:0]          r_pack [NUM_CH];
    logic [AW-1:0]          r_wptr, r_addr;
    logic [NUM_CH*WW-1:0]   r_din;
    logic                   r_we;
    logic [AW:0]            r_word_count;

    logic                   w_accept, w_lane_last;
    logic [LW-1:0]          w_lane_next;
    logic signed [DW-1:0]   w_term;
    logic signed [SW-1:0]   w_sum       [NUM_CH];
    logic signed [SW-1:0]   w_relu_val  [NUM_CH];
    logic [7:0]             w_byte      [NUM_CH];
    logic [WW-1:0]          w_pack_next [NUM_CH];

    assign w_accept = (r_state == S_RUN) && bus.sum_valid;

    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_term = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum[c] = '0;
            for (int k = 0; k < NUM_TERMS; k++) begin
                w_term   = bus.sum_in[(c*NUM_TERMS+k)*DW +: DW];
                w_sum[c] = w_sum[c] + SW'(w_term);
            end
        end
    end

    // ReLU first, then either saturate to signed 8-bit or keep the low byte.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            w_relu_val[c] = (r_s1_relu && r_s1_sum[c] < 0) ? '0 : r_s1_sum[c];
            if (!r_s1_sat)                  w_byte[c] = w_relu_val[c][7:0];
            else if (w_relu_val[c] > SAT_MAX) w_byte[c] = 8'h7F;
            else if (w_relu_val[c] < SAT_MIN) w_byte[c] = 8'h80;
            else                            w_byte[c] = w_relu_val[c][7:0];
        end
    end

    always_comb begin
        w_lane_last = (r_lane == LW'(LANES - 1));
        w_lane_next = r_lane;
        for (int c = 0; c < NUM_CH; c++) w_pack_next[c] = r_pack[c];
        if (r_s2_valid) begin
            w_lane_next = w_lane_last ? '0 : r_lane + LW'(1);
            for (int c = 0; c < NUM_CH; c++)
                w_pack_next[c][WW-1-8*int'(r_lane) -: 8] = r_s2_byte[c];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the small per-channel
    // arrays are reset along with everything else since they are plain flops, not RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s1_relu  <= 1'b0;
            r_s1_sat   <= 1'b0;
            r_s2_valid <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_s1_sum[c]  <= '0;
                r_s2_byte[c] <= '0;
            end
        end else if (bus.start) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            if (w_accept) begin
                r_s1_relu <= bus.relu_en;
                r_s1_sat  <= bus.sat_en;
                for (int c = 0; c < NUM_CH; c++) r_s1_sum[c] <= w_sum[c];
            end
            if (r_s1_valid)
                for (int c = 0; c < NUM_CH; c++) r_s2_byte[c] <= w_byte[c];
        end
    end

    // A write fires on the byte that fills the word, or once in FLUSH for a partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_wptr       <= '0;
            r_word_count <= '0;
            r_lane       <= '0;
            for (int c = 0; c < NUM_CH; c++) r_pack[c] <= '0;
        end else begin
            r_we <= 1'b0;
            if (bus.start) begin
                r_wptr       <= bus.base_addr;
                r_word_count <= '0;
                r_lane       <= '0;
                for (int c = 0; c < NUM_CH; c++) r_pack[c] <= '0;
            end else if ((r_s2_valid && w_lane_last) || r_state == S_FLUSH) begin
                r_we         <= 1'b1;
                r_addr       <= r_wptr;
                r_wptr       <= r_wptr + AW'(1);
                r_word_count <= r_word_count + (AW+1)'(1);
                r_lane       <= '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_din[c*WW +: WW] <= w_pack_next[c];
                    r_pack[c]         <= '0;
                end
            end else if (r_s2_valid) begin
                r_lane <= w_lane_next;
                for (int c = 0; c < NUM_CH; c++) r_pack[c] <= w_pack_next[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= (r_state == S_DRAIN && !bus.start) ? ~r_drain_cnt : 1'b0;
        end
    end

    // The DRAIN exit looks at the lane index after the last in-flight byte lands.
    always_comb begin
        w_state_next = r_state;
        if (bus.start) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = S_IDLE;
                S_RUN:   if (bus.flush) w_state_next = S_DRAIN;
                S_DRAIN: if (r_drain_cnt)
                             w_state_next = (w_lane_next != '0) ? S_FLUSH : S_DONE;
                S_FLUSH: w_state_next = S_DONE;
                S_DONE:  w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    assign bus.we         = r_we;
    assign bus.addr       = r_addr;
    assign bus.din        = r_din;
    assign bus.word_count = r_word_count;
    assign bus.busy       = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_FLUSH);
    assign bus.done       = (r_state == S_DONE);
endmodule
